mfi_reg_check: RTL and testbench



---
 rtl/mfi_reg_check.sv | 115 +++++++++++
 tb/tb_mfi_reg_check.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfi_reg_check.sv
// mfi_reg_check: shadow register file built from retired destination writes; each retired source read is checked against it.
// Latency: err/err_code/err_order update one cycle after the offending beat; a write at beat N is checked by beat N+1.
// Backpressure: none, one beat per cycle is always accepted. `MFI_ORDER_CHECK_EN adds the retirement order continuity check.
module mfi_reg_check #(
    parameter int ZERO_REG = 1,
    parameter int XLEN     = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mfi_valid,
    input  logic [31:0]     mfi_order,
    input  logic            mfi_trap,
    input  logic [3:0]      mfi_src1_addr,
    input  logic [XLEN-1:0] mfi_src1_rdata,
    input  logic [3:0]      mfi_src2_addr,
    input  logic [XLEN-1:0] mfi_src2_rdata,
    input  logic [3:0]      mfi_dest_addr,
    input  logic [XLEN-1:0] mfi_dest_wdata,
    output logic            err,
    output logic [1:0]      err_code,
    output logic [31:0]     err_order,
    output logic [15:0]     check_count
);

    localparam logic [1:0] CODE_NONE  = 2'd0;
    localparam logic [1:0] CODE_SRC1  = 2'd1;
    localparam logic [1:0] CODE_SRC2  = 2'd2;
    localparam logic [1:0] CODE_ORDER = 2'd3;

    localparam logic [15:0] KNOWN_RST = (ZERO_REG != 0) ? 16'h0001 : 16'h0000;

    logic [XLEN-1:0] shadow [16];
    logic [15:0]     known;

    logic       src1_bad;
    logic       src2_bad;
    logic       order_bad;
    logic       dest_wr;
    logic [1:0] beat_code;

`ifdef MFI_ORDER_CHECK_EN
    logic        order_base_vld;
    logic [31:0] order_last;

    // Baseline is taken from the first beat after reset; trapped beats still advance it.
    always_ff @(posedge clock) begin
        if (reset) begin
            order_base_vld <= 1'b0;
            order_last     <= '0;
        end else if (mfi_valid) begin
            order_base_vld <= 1'b1;
            order_last     <= mfi_order;
        end
    end

    assign order_bad = order_base_vld && (mfi_order != order_last + 32'd1);
`else
    assign order_bad = 1'b0;
`endif

    // Sources compare against the pre-update shadow, so a self-dependent beat checks the old value.
    always_comb begin
        src1_bad  = known[mfi_src1_addr] && (mfi_src1_rdata != shadow[mfi_src1_addr]);
        src2_bad  = known[mfi_src2_addr] && (mfi_src2_rdata != shadow[mfi_src2_addr]);
        dest_wr   = mfi_valid && !mfi_trap && !((ZERO_REG != 0) && (mfi_dest_addr == 4'd0));
        beat_code = CODE_NONE;
        if (src1_bad) begin
            beat_code = CODE_SRC1;
        end else if (src2_bad) begin
            beat_code = CODE_SRC2;
        end else if (order_bad) begin
            beat_code = CODE_ORDER;
        end
    end

    // Only entry 0 needs a defined value; other entries are masked by known until written.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (ZERO_REG != 0) begin
                shadow[0] <= '0;
            end
        end else if (dest_wr) begin
            shadow[mfi_dest_addr] <= mfi_dest_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            known <= KNOWN_RST;
        end else if (dest_wr) begin
            known[mfi_dest_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err       <= 1'b0;
            err_code  <= CODE_NONE;
            err_order <= '0;
        end else if (mfi_valid && !err && (beat_code != CODE_NONE)) begin
            err       <= 1'b1;
            err_code  <= beat_code;
            err_order <= mfi_order;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            check_count <= '0;
        end else if (mfi_valid && (check_count != 16'hFFFF)) begin
            check_count <= check_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mfi_reg_check.sv
// Testbench for mfi_reg_check: directed scenarios plus randomized beats against a behavioural shadow model.
module tb_mfi_reg_check;

    localparam int XLEN     = 32;
    localparam int ZERO_REG = 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            mfi_valid;
    logic [31:0]     mfi_order;
    logic            mfi_trap;
    logic [3:0]      mfi_src1_addr;
    logic [XLEN-1:0] mfi_src1_rdata;
    logic [3:0]      mfi_src2_addr;
    logic [XLEN-1:0] mfi_src2_rdata;
    logic [3:0]      mfi_dest_addr;
    logic [XLEN-1:0] mfi_dest_wdata;
    logic            err;
    logic [1:0]      err_code;
    logic [31:0]     err_order;
    logic [15:0]     check_count;

    always #5 clock = ~clock;

    mfi_reg_check #(.ZERO_REG(ZERO_REG), .XLEN(XLEN)) dut (
        .clock          (clock),
        .reset          (reset),
        .mfi_valid      (mfi_valid),
        .mfi_order      (mfi_order),
        .mfi_trap       (mfi_trap),
        .mfi_src1_addr  (mfi_src1_addr),
        .mfi_src1_rdata (mfi_src1_rdata),
        .mfi_src2_addr  (mfi_src2_addr),
        .mfi_src2_rdata (mfi_src2_rdata),
        .mfi_dest_addr  (mfi_dest_addr),
        .mfi_dest_wdata (mfi_dest_wdata),
        .err            (err),
        .err_code       (err_code),
        .err_order      (err_order),
        .check_count    (check_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural register view plus first-error record.
    logic [XLEN-1:0] m_regs [16];
    logic            m_known [16];
    logic            m_err;
    logic [1:0]      m_code;
    logic [31:0]     m_order;
    int              m_cnt;
    logic            m_base_vld;
    logic [31:0]     m_last;
    logic [31:0]     next_ord;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_regs[i]  = '0;
            m_known[i] = 1'b0;
        end
        m_known[0] = (ZERO_REG != 0);
        m_err      = 1'b0;
        m_code     = 2'd0;
        m_order    = '0;
        m_cnt      = 0;
        m_base_vld = 1'b0;
        m_last     = '0;
    endtask

    task automatic model_beat(input logic [31:0] ord, input logic trap,
                              input logic [3:0] s1, input logic [XLEN-1:0] r1,
                              input logic [3:0] s2, input logic [XLEN-1:0] r2,
                              input logic [3:0] dst, input logic [XLEN-1:0] w);
        logic [1:0] code;
        code = 2'd0;
        if (m_known[s1] && m_regs[s1] != r1) code = 2'd1;
        else if (m_known[s2] && m_regs[s2] != r2) code = 2'd2;
`ifdef MFI_ORDER_CHECK_EN
        else if (m_base_vld && ord != m_last + 32'd1) code = 2'd3;
`endif
        if (!m_err && code != 2'd0) begin
            m_err   = 1'b1;
            m_code  = code;
            m_order = ord;
        end
        if (!trap && !(ZERO_REG != 0 && dst == 4'd0)) begin
            m_regs[dst]  = w;
            m_known[dst] = 1'b1;
        end
        if (m_cnt < 65535) m_cnt++;
        m_base_vld = 1'b1;
        m_last     = ord;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mfi_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic beat(input logic trap,
                        input logic [3:0] s1, input logic [XLEN-1:0] r1,
                        input logic [3:0] s2, input logic [XLEN-1:0] r2,
                        input logic [3:0] dst, input logic [XLEN-1:0] w);
        mfi_valid      = 1'b1;
        mfi_order      = next_ord;
        mfi_trap       = trap;
        mfi_src1_addr  = s1;
        mfi_src1_rdata = r1;
        mfi_src2_addr  = s2;
        mfi_src2_rdata = r2;
        mfi_dest_addr  = dst;
        mfi_dest_wdata = w;
        @(posedge clock);
        #1;
        model_beat(next_ord, trap, s1, r1, s2, r2, dst, w);
        next_ord  = next_ord + 32'd1;
        mfi_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err actual=%0b required=0", err); end
        n_cmp++;
        if (err_code !== 2'd0) begin n_bad++; $display("FAIL reset_code actual=%0d required=0", err_code); end
        n_cmp++;
        if (err_order !== 32'd0) begin n_bad++; $display("FAIL reset_order actual=%h required=0", err_order); end
        n_cmp++;
        if (check_count !== 16'd0) begin n_bad++; $display("FAIL reset_count actual=%0d required=0", check_count); end
    endtask

    task automatic test_dependent();
        do_reset();
        beat(1'b0, 4'd0, '0, 4'd0, '0, 4'd3, 32'h1234);
        beat(1'b0, 4'd3, 32'h1234, 4'd0, '0, 4'd1, 32'h0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL dep_err actual=%0b required=0", err); end
        n_cmp++;
        if (check_count !== 16'd2) begin n_bad++; $display("FAIL dep_count actual=%0d required=2", check_count); end
    endtask

    task automatic test_stale_forward();
        do_reset();
        beat(1'b0, 4'd0, '0, 4'd0, '0, 4'd3, 32'h1234);
        next_ord = 32'd7;
        beat(1'b0, 4'd3, 32'h0, 4'd0, '0, 4'd1, 32'h0);
        n_cmp++;
        if (err !== 1'b1 || err_code !== 2'd1 || err_order !== 32'd7) begin
            n_bad++;
            $display("FAIL stale_fwd actual err=%0b code=%0d order=%0d required err=1 code=1 order=7", err, err_code, err_order);
        end
    endtask

    task automatic test_unknown_zero();
        do_reset();
        beat(1'b0, 4'd0, '0, 4'd5, 32'hDEAD, 4'd1, 32'h0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL unknown_reg actual=%0b required=0", err); end
        beat(1'b0, 4'd0, '0, 4'd0, '0, 4'd0, 32'hFF);
        beat(1'b0, 4'd0, 32'h0, 4'd0, '0, 4'd1, 32'h0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL zero_reg_write actual=%0b required=0", err); end
        beat(1'b0, 4'd0, '0, 4'd0, 32'hFF, 4'd1, 32'h0);
        n_cmp++;
        if (err !== 1'b1 || err_code !== 2'd2) begin
            n_bad++;
            $display("FAIL zero_reg_read actual err=%0b code=%0d required err=1 code=2", err, err_code);
        end
    endtask

    task automatic test_trap_self();
        do_reset();
        beat(1'b0, 4'd0, '0, 4'd0, '0, 4'd4, 32'd1);
        beat(1'b1, 4'd0, '0, 4'd0, '0, 4'd4, 32'd9);
        beat(1'b0, 4'd4, 32'd1, 4'd0, '0, 4'd2, 32'd0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL trap_no_write actual=%0b required=0", err); end
        beat(1'b0, 4'd4, 32'd1, 4'd0, '0, 4'd4, 32'd2);
        beat(1'b0, 4'd4, 32'd2, 4'd0, '0, 4'd2, 32'd0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL self_dep actual=%0b required=0", err); end
        n_cmp++;
        if (check_count !== 16'd5) begin n_bad++; $display("FAIL trap_count actual=%0d required=5", check_count); end
    endtask

    task automatic test_order();
        do_reset();
        next_ord = 32'hFFFF_FFFE;
        beat(1'b0, 4'd0, '0, 4'd0, '0, 4'd1, 32'd0);
        beat(1'b1, 4'd0, '0, 4'd0, '0, 4'd1, 32'd0);
        beat(1'b0, 4'd0, '0, 4'd0, '0, 4'd1, 32'd0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL order_wrap actual=%0b required=0", err); end
        next_ord = 32'd2;
        beat(1'b0, 4'd0, '0, 4'd0, '0, 4'd1, 32'd0);
`ifdef MFI_ORDER_CHECK_EN
        n_cmp++;
        if (err !== 1'b1 || err_code !== 2'd3 || err_order !== 32'd2) begin
            n_bad++;
            $display("FAIL order_gap actual err=%0b code=%0d order=%0d required err=1 code=3 order=2", err, err_code, err_order);
        end
`else
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL order_gap_disabled actual=%0b required=0", err); end
`endif
    endtask

    task automatic test_first_error_latch();
        do_reset();
        beat(1'b0, 4'd0, '0, 4'd0, '0, 4'd6, 32'hA);
        next_ord = 32'd20;
        beat(1'b0, 4'd6, 32'hB, 4'd0, '0, 4'd1, 32'd0);
        beat(1'b0, 4'd0, '0, 4'd6, 32'hC, 4'd1, 32'd0);
        n_cmp++;
        if (err_code !== 2'd1 || err_order !== 32'd20) begin
            n_bad++;
            $display("FAIL first_err_latch actual code=%0d order=%0d required code=1 order=20", err_code, err_order);
        end
        n_cmp++;
        if (check_count !== 16'd3) begin n_bad++; $display("FAIL count_after_err actual=%0d required=3", check_count); end
    endtask

    task automatic test_reset_with_beat();
        do_reset();
        beat(1'b0, 4'd0, '0, 4'd0, '0, 4'd9, 32'h55);
        beat(1'b0, 4'd9, 32'h0, 4'd0, '0, 4'd1, 32'd0);
        reset          = 1'b1;
        mfi_valid      = 1'b1;
        mfi_order      = 32'd99;
        mfi_trap       = 1'b0;
        mfi_src1_addr  = 4'd9;
        mfi_src1_rdata = 32'h0;
        mfi_src2_addr  = 4'd0;
        mfi_src2_rdata = '0;
        mfi_dest_addr  = 4'd9;
        mfi_dest_wdata = 32'h77;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        mfi_valid = 1'b0;
        model_reset();
        n_cmp++;
        if (err !== 1'b0 || err_code !== 2'd0 || err_order !== 32'd0 || check_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_beat actual err=%0b code=%0d order=%0d cnt=%0d required all 0", err, err_code, err_order, check_count);
        end
        beat(1'b0, 4'd9, 32'h1, 4'd0, '0, 4'd1, 32'd0);
        n_cmp++;
        if (err !== 1'b0 || check_count !== 16'd1) begin
            n_bad++;
            $display("FAIL reset_forgets actual err=%0b cnt=%0d required err=0 cnt=1", err, check_count);
        end
    endtask

    task automatic test_random();
        logic [3:0]      s1, s2, dst;
        logic [XLEN-1:0] r1, r2;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                mfi_valid = 1'b0;
                @(posedge clock);
                #1;
            end else begin
                s1  = 4'($urandom_range(0, 7));
                s2  = 4'($urandom_range(0, 7));
                dst = 4'($urandom_range(0, 7));
                r1  = m_known[s1] ? m_regs[s1] : XLEN'($urandom);
                r2  = m_known[s2] ? m_regs[s2] : XLEN'($urandom);
                if ($urandom_range(0, 24) == 0) r1 = r1 ^ XLEN'($urandom_range(1, 255));
                if ($urandom_range(0, 24) == 0) r2 = r2 ^ XLEN'($urandom_range(1, 255));
                if ($urandom_range(0, 39) == 0) next_ord = next_ord + 32'($urandom_range(2, 9));
                beat($urandom_range(0, 7) == 0, s1, r1, s2, r2, dst, XLEN'($urandom));
            end
            n_cmp++;
            if (err !== m_err || err_code !== m_code || err_order !== m_order || check_count !== 16'(m_cnt)) begin
                n_bad++;
                $display("FAIL random cyc=%0d err=%0b/%0b code=%0d/%0d order=%h/%h cnt=%0d/%0d (actual/required)",
                         cyc, err, m_err, err_code, m_code, err_order, m_order, check_count, m_cnt);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        mfi_valid      = 1'b0;
        mfi_order      = '0;
        mfi_trap       = 1'b0;
        mfi_src1_addr  = '0;
        mfi_src1_rdata = '0;
        mfi_src2_addr  = '0;
        mfi_src2_rdata = '0;
        mfi_dest_addr  = '0;
        mfi_dest_wdata = '0;
        next_ord       = '0;
        model_reset();
        test_reset();
        test_dependent();
        test_stale_forward();
        test_unknown_zero();
        test_trap_self();
        test_order();
        test_first_error_latch();
        test_reset_with_beat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
